ram_rr_arbiter: RTL

- Round-robin arbiter/controller that shares one single-port synchronous RAM (1 access/cycle, 1-cycle registered read) between two requesters.
- After reset it sequences a zero-fill of every RAM word, then serves requests with throughput of one access per cycle.
- Sits between two client blocks and the 128x32 RAM instance; drives the RAM write enable, address and data and returns read data to the granted requester.

---
 rtl/ram_rr_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous RAM.
// After reset every word is zero-filled. The arbiter then grants at most one
// access per cycle and returns read data one cycle after the read grant.
module ram_rr_arbiter #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [Addr_width-1:0] addr0,
    input  logic [Data_width-1:0] d0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [Data_width-1:0] q0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [Addr_width-1:0] addr1,
    input  logic [Data_width-1:0] d1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [Data_width-1:0] q1,
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_address,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q,
    output logic                  init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [Addr_width-1:0] LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic [Addr_width-1:0] init_cnt_q, init_cnt_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_id_q, rd_id_d;
    logic                  win0, win1;

    // Same-cycle arbitration: a lone requester wins, a tie goes to rr_ptr.
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (state_q == ST_RUN && !reset) begin
            win0 = req0 && (!req1 || !rr_ptr_q);
            win1 = req1 && (!req0 || rr_ptr_q);
        end
    end

    // Next-state logic and RAM drive for zero-fill and normal service.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rd_valid_d  = 1'b0;
        rd_id_d     = rd_id_q;
        ram_we      = 1'b0;
        ram_address = '0;
        ram_d       = '0;
        if (state_q == ST_INIT) begin
            ram_we      = 1'b1;
            ram_address = init_cnt_q;
            init_cnt_d  = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end else if (win0) begin
            ram_we      = we0;
            ram_address = addr0;
            ram_d       = d0;
            rr_ptr_d    = 1'b1;
            rd_valid_d  = !we0;
            rd_id_d     = 1'b0;
        end else if (win1) begin
            ram_we      = we1;
            ram_address = addr1;
            ram_d       = d1;
            rr_ptr_d    = 1'b0;
            rd_valid_d  = !we1;
            rd_id_d     = 1'b1;
        end
        // While reset is held the RAM sees the first fill write (address 0, data 0).
        if (reset) begin
            ram_we      = 1'b1;
            ram_address = '0;
            ram_d       = '0;
        end
    end

    // State registers; reset restarts the zero-fill and drops any pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rr_ptr_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Read data returns to the requester tagged one cycle earlier; a
    // return that lands on a reset cycle is suppressed.
    always_comb begin
        gnt0      = win0;
        gnt1      = win1;
        rvalid0   = rd_valid_q && !rd_id_q && !reset;
        rvalid1   = rd_valid_q && rd_id_q && !reset;
        q0        = ram_q;
        q1        = ram_q;
        init_done = (state_q == ST_RUN) && !reset;
    end

endmodule
